record_core: RTL and testbench
==============================

# record_core

Capture engine for the recording path, the write-side counterpart of the playback engine. It accepts 32-bit audio sample words from the audio interface over a valid/ready handshake and buffers them in a small FIFO. It writes them sequentially to SDRAM through the shared single-word write port, then writes the sample count into the slot header. It sits between the top-level controller, the audio front end and the SDRAM arbiter. It produces the slot format the player consumes: word at `base` = length N, samples at `base+1 .. base+N`.

## Interface
- `FIFO_DEPTH`, default 4: sample buffer entries; power of two, 2..16.
- `MAX_SAMPLES`, default 23'h3F_FFFF: slot capacity in sample words; capture ends automatically when the count reaches this value.
- `i_clk`  in  1: sole clock.
- `i_rst`  in  1: reset; synchronous, active-high.
- `rec_start`  in  1: begin capture into slot `rec_select`; sampled in IDLE only.
- `rec_select`  in  23: slot base address; latched on accepted start.
- `rec_pause`  in  1: level; while high no new samples are accepted.
- `rec_stop`  in  1: end capture (pulse or level).
- `rec_done`  out  1: one-cycle pulse when the header write completes.
- `rec_write`  out  1: SDRAM write request, held until finished.
- `rec_addr`  out  23: SDRAM word address.
- `rec_writedata`  out  32: SDRAM write data.
- `rec_sdram_finished`  in  1: one-cycle acknowledge of the current write.
- `rec_audio_valid`  in  1: sample available.
- `rec_audio_data`  in  32: sample word.
- `rec_audio_ready`  out  1: block accepts the sample this cycle.

## Operation
- States: IDLE, CAPTURE, DRAIN, WRITE_LENGTH.
- IDLE:
  - `rec_start=1` latches `base<=rec_select`, clears `count` and the FIFO, and moves to CAPTURE.
  - `rec_stop` is ignored.
- CAPTURE:
  - `rec_audio_ready = !fifo_full && !rec_pause && (count + fifo_level < MAX_SAMPLES)`.
  - A sample is accepted on an edge with valid and ready both high; it is pushed to the FIFO.
  - Push and pop in the same cycle are legal; the level is unchanged.
- Write engine, active in CAPTURE and DRAIN:
  - When the FIFO is non-empty: `rec_write=1`, `rec_addr = base + 1 + count`, `rec_writedata` = FIFO head.
  - Address and data are held stable until `rec_sdram_finished`.
  - On finished: pop the FIFO and `count <= count + 1`.
- CAPTURE -> DRAIN when `rec_stop` is seen, or when `count + fifo_level` reaches MAX_SAMPLES.
  - A sample accepted on the same edge as the stop is kept.
- DRAIN:
  - `rec_audio_ready=0`.
  - Writes continue until the FIFO is empty, then the block moves to WRITE_LENGTH.
  - If the FIFO is already empty on entry, the move happens on the next edge.
- WRITE_LENGTH:
  - `rec_write=1`, `rec_addr=base`, `rec_writedata={9'b0,count}`.
  - On finished: `rec_done=1` in that same cycle, then IDLE.
- `rec_stop` in DRAIN or WRITE_LENGTH has no effect; the header is always written.
- `rec_start` outside IDLE is ignored.
- Address arithmetic is 23-bit modulo 2^23. `base + 1 + count` wraps silently; the controller guarantees slot placement.
- A zero-length capture (stop before any sample) writes header value 0.
- `rec_pause` while in DRAIN or WRITE_LENGTH has no effect.

## Timing
- Reset: state IDLE, FIFO empty, `count=0`, `base=0`. Outputs: `rec_write=0`, `rec_addr=0`, `rec_writedata=0`, `rec_audio_ready=0`, `rec_done=0`.
- Reset asserted mid-write drops `rec_write` at the next edge. No header is written.
- `rec_start` at edge k: `rec_audio_ready` may be high in cycle k+1.
- A sample accepted at edge k gives `rec_write=1` in cycle k+1 at the earliest (registered FIFO).
- A finished pulse in cycle m pops the FIFO at edge m. The next queued word is presented with `rec_write=1` in cycle m+1.
- Outputs are driven from registered state and the FIFO head only. `rec_audio_ready` has no combinational path from `rec_audio_valid`.
- With `rec_pause=1`, ready is low from the same cycle. Pending FIFO entries are still written.
- `rec_done` is asserted only in the cycle of the header's finished pulse. It is never asserted twice per capture.

## Test plan
- Basic capture:
  - Stimulus: start with `rec_select=23'h100`; valid held high with data 0xA0..0xA4 (5 samples); SDRAM finishes after 2 cycles; stop.
  - Required: writes to 0x101..0x105 with 0xA0..0xA4, then header 0x100 <- 5, then one `rec_done` pulse.
- Backpressure:
  - Stimulus: SDRAM finished delayed 20 cycles; valid held high.
  - Required: ready drops after 4 accepted samples; no sample is lost or duplicated; the addresses are strictly sequential.
- Pause:
  - Stimulus: pause asserted for 10 cycles mid-stream.
  - Required: no handshakes during the pause; the queued writes complete; the count is continuous after release.
- Stop with a full FIFO:
  - Stimulus: stop while 4 entries are queued.
  - Required: all 4 written, then header = total count; ready stays 0 after the stop.
- Capacity limit:
  - Stimulus: `MAX_SAMPLES=3`, 6 samples offered.
  - Required: exactly 3 accepted, header value 3, `rec_done` asserted with no stop.
- Reset during WRITE_LENGTH, then a new start with `rec_select=23'h200` and a zero-length stop:
  - Required: `rec_write` low after the reset edge; the new capture yields header 0x200 <- 0 and `rec_done`.

Source files
------------

// File: rtl/record_core.sv
// Recording capture engine: buffers audio samples in a small FIFO, streams them
// to SDRAM at base+1.., then writes the sample count into the slot header at base.
module record_core #(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [22:0] MAX_SAMPLES = 23'h3F_FFFF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        rec_start,
    input  logic [22:0] rec_select,
    input  logic        rec_pause,
    input  logic        rec_stop,
    output logic        rec_done,
    output logic        rec_write,
    output logic [22:0] rec_addr,
    output logic [31:0] rec_writedata,
    input  logic        rec_sdram_finished,
    input  logic        rec_audio_valid,
    input  logic [31:0] rec_audio_data,
    output logic        rec_audio_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN, S_WRITE_LENGTH} state_t;

    state_t                       state_q, state_d;
    logic [22:0]                  base_q, base_d;
    logic [22:0]                  count_q, count_d;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                level_q, level_d;
    logic [FIFO_DEPTH-1:0][31:0]  mem_q, mem_d;

    logic        fifo_full, fifo_empty, wr_active, push, pop;
    logic [23:0] fill, fill_d;

    // fill = samples committed to this slot (written + queued); 24 bits so it cannot wrap
    always_comb begin
        fifo_empty      = (level_q == '0);
        fifo_full       = (level_q == LW'(FIFO_DEPTH));
        fill            = {1'b0, count_q} + {{(24-LW){1'b0}}, level_q};
        rec_audio_ready = (state_q == S_CAPTURE) && !fifo_full && !rec_pause &&
                          (fill < {1'b0, MAX_SAMPLES});
        push            = rec_audio_ready && rec_audio_valid;
        wr_active       = ((state_q == S_CAPTURE) || (state_q == S_DRAIN)) && !fifo_empty;
        pop             = wr_active && rec_sdram_finished;
    end

    always_comb begin
        rec_write     = wr_active || (state_q == S_WRITE_LENGTH);
        rec_addr      = '0;
        rec_writedata = '0;
        rec_done      = (state_q == S_WRITE_LENGTH) && rec_sdram_finished;
        if (wr_active) begin
            rec_addr      = base_q + 23'd1 + count_q;
            rec_writedata = mem_q[rd_ptr_q];
        end else if (state_q == S_WRITE_LENGTH) begin
            rec_addr      = base_q;
            rec_writedata = {9'b0, count_q};
        end
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        mem_d    = mem_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        count_d  = pop ? count_q + 23'd1 : count_q;
        if (push) mem_d[wr_ptr_q] = rec_audio_data;
        fill_d   = {1'b0, count_d} + {{(24-LW){1'b0}}, level_d};

        case (state_q)
            S_IDLE: begin
                if (rec_start) begin
                    base_d   = rec_select;
                    count_d  = '0;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    level_d  = '0;
                    state_d  = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                // a sample pushed on the stop edge is already in level_d and gets drained
                if (rec_stop || (fill_d >= {1'b0, MAX_SAMPLES})) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (level_d == '0) state_d = S_WRITE_LENGTH;
            end
            S_WRITE_LENGTH: begin
                if (rec_sdram_finished) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            mem_q    <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end
endmodule

// File: tb/tb_record_core.sv
// Directed bench for record_core: default-parameter instance for the main flows,
// plus a MAX_SAMPLES=3 instance for the capacity limit.
module tb_record_core;
    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // instance A: default parameters
    logic        rec_start, rec_pause, rec_stop, rec_done, rec_write, fin;
    logic [22:0] rec_select, rec_addr;
    logic [31:0] rec_wdata, a_data;
    logic        a_valid, a_ready;

    record_core dut (
        .i_clk(clk), .i_rst(rst), .rec_start(rec_start), .rec_select(rec_select),
        .rec_pause(rec_pause), .rec_stop(rec_stop), .rec_done(rec_done),
        .rec_write(rec_write), .rec_addr(rec_addr), .rec_writedata(rec_wdata),
        .rec_sdram_finished(fin), .rec_audio_valid(a_valid),
        .rec_audio_data(a_data), .rec_audio_ready(a_ready)
    );

    // instance B: capacity of 3 samples
    logic        b_start, b_pause, b_stop, b_done, b_write, b_fin, b_valid, b_ready;
    logic [22:0] b_select, b_addr;
    logic [31:0] b_wdata, b_data;

    record_core #(.FIFO_DEPTH(4), .MAX_SAMPLES(23'd3)) dut_cap (
        .i_clk(clk), .i_rst(rst), .rec_start(b_start), .rec_select(b_select),
        .rec_pause(b_pause), .rec_stop(b_stop), .rec_done(b_done),
        .rec_write(b_write), .rec_addr(b_addr), .rec_writedata(b_wdata),
        .rec_sdram_finished(b_fin), .rec_audio_valid(b_valid),
        .rec_audio_data(b_data), .rec_audio_ready(b_ready)
    );

    int n_checks = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // SDRAM models: acknowledge each write after a programmable latency
    int lat = 2, wcnt = 0;
    always @(posedge clk) begin
        if (rec_write && !fin) begin
            if (wcnt + 1 >= lat) begin fin <= 1'b1; wcnt <= 0; end
            else wcnt <= wcnt + 1;
        end else begin
            fin <= 1'b0; wcnt <= 0;
        end
    end
    always @(posedge clk) b_fin <= b_write && !b_fin;

    // write logs, done counters and hold-stability monitor
    logic [22:0] wa[$], ba[$];
    logic [31:0] wd[$], bd[$];
    int done_cnt = 0, b_done_cnt = 0, stab_err = 0;
    logic        p_write = 1'b0, p_fin = 1'b0;
    logic [22:0] p_addr;
    logic [31:0] p_data;
    always @(negedge clk) begin
        if (rec_write && fin) begin wa.push_back(rec_addr); wd.push_back(rec_wdata); end
        if (b_write && b_fin) begin ba.push_back(b_addr); bd.push_back(b_wdata); end
        if (rec_done) done_cnt++;
        if (b_done) b_done_cnt++;
        if (p_write && rec_write && !p_fin && (rec_addr !== p_addr || rec_wdata !== p_data))
            stab_err++;
        p_write = rec_write; p_fin = fin; p_addr = rec_addr; p_data = rec_wdata;
    end

    // feed() bookkeeping
    int acc, first_block, hs_pause, log_at_pause, pause_at = -1, pause_len = 0;

    task automatic start(input logic [22:0] sel);
        @(negedge clk); rec_select = sel; rec_start = 1'b1;
        @(negedge clk); rec_start = 1'b0;
    endtask

    task automatic stop_pulse();
        @(negedge clk); rec_stop = 1'b1;
        @(negedge clk); rec_stop = 1'b0;
    endtask

    task automatic feed(input int n, input logic [31:0] d0, input int budget);
        bit paused = 0;
        acc = 0; first_block = -1; hs_pause = 0; log_at_pause = -1;
        for (int cyc = 0; cyc < budget && acc < n; cyc++) begin
            @(negedge clk);
            if (acc == pause_at && !paused) begin
                paused = 1; rec_pause = 1'b1;
                for (int p = 0; p < pause_len; p++) begin
                    if (p > 0) @(negedge clk);
                    a_valid = 1'b1; a_data = d0 + acc; #1;
                    if (a_ready) hs_pause++;
                end
                log_at_pause = wa.size();
            end else begin
                rec_pause = 1'b0; a_valid = 1'b1; a_data = d0 + acc; #1;
                if (a_ready) acc++;
                else if (first_block < 0) first_block = acc;
            end
        end
        @(negedge clk); a_valid = 1'b0; rec_pause = 1'b0;
        if (acc < n) chk("feed_timeout", acc, n);
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int t = 0;
        while (done_cnt == d0 && t < budget) begin @(negedge clk); #1; t++; end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
    endtask

    typedef struct {
        logic [31:0] din;
        logic [22:0] addr;
        logic [31:0] wdata;
    } vec_t;
    vec_t vec[6];

    initial begin
        int hdr, rdy_after, bacc;
        for (int i = 0; i < 5; i++) vec[i] = '{32'hA0 + i, 23'h101 + i, 32'hA0 + i};
        vec[5] = '{32'h0, 23'h100, 32'd5};

        rst = 1'b1; rec_start = 0; rec_select = 0; rec_pause = 0; rec_stop = 0;
        a_valid = 0; a_data = 0; fin = 0;
        b_start = 0; b_select = 0; b_pause = 0; b_stop = 0; b_valid = 0; b_data = 0; b_fin = 0;
        repeat (3) @(negedge clk);
        chk("rst_write", rec_write, 0);
        chk("rst_addr", rec_addr, 0);
        chk("rst_wdata", rec_wdata, 0);
        chk("rst_ready", a_ready, 0);
        chk("rst_done", rec_done, 0);
        rst = 1'b0;

        // basic capture
        lat = 2;
        start(23'h100);
        feed(5, 32'hA0, 100);
        stop_pulse();
        wait_done(200);
        chk("basic_nwrites", wa.size(), 6);
        for (int i = 0; i < 6 && i < wa.size(); i++) begin
            chk($sformatf("basic_addr%0d", i), wa[i], vec[i].addr);
            chk($sformatf("basic_data%0d", i), wd[i], vec[i].wdata);
        end
        repeat (5) @(negedge clk);
        chk("basic_done_once", done_cnt, 1);

        // backpressure
        wa.delete(); wd.delete(); lat = 20;
        start(23'h300);
        feed(8, 32'hB0, 400);
        chk("bp_block_at", first_block, 4);
        stop_pulse();
        wait_done(400);
        chk("bp_nwrites", wa.size(), 9);
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            chk($sformatf("bp_addr%0d", i), wa[i], 23'h301 + i);
            chk($sformatf("bp_data%0d", i), wd[i], 32'hB0 + i);
        end
        if (wa.size() == 9) begin chk("bp_hdr_addr", wa[8], 23'h300); chk("bp_hdr_val", wd[8], 8); end

        // pause mid-stream
        wa.delete(); wd.delete(); lat = 2; pause_at = 2; pause_len = 10;
        start(23'h400);
        feed(6, 32'hC0, 200);
        pause_at = -1;
        chk("pause_no_hs", hs_pause, 0);
        chk("pause_drained", log_at_pause, 2);
        stop_pulse();
        wait_done(200);
        chk("pause_nwrites", wa.size(), 7);
        for (int i = 0; i < 6 && i < wa.size(); i++)
            chk($sformatf("pause_data%0d", i), {wa[i][7:0], wd[i][23:0]}, {8'h01 + 8'(i), 24'hC0 + 24'(i)});
        if (wa.size() == 7) chk("pause_hdr", wd[6], 6);

        // stop with a full FIFO, valid kept high afterwards
        wa.delete(); wd.delete(); lat = 20;
        start(23'h500);
        feed(4, 32'hD0, 20);
        rdy_after = 0; hdr = done_cnt;
        @(negedge clk); rec_stop = 1'b1; a_valid = 1'b1; a_data = 32'hDEAD; #1;
        if (a_ready) rdy_after++;
        for (int t = 0; t < 300 && done_cnt == hdr; t++) begin
            @(negedge clk); rec_stop = 1'b0; #1;
            if (a_ready) rdy_after++;
        end
        a_valid = 1'b0;
        chk("full_ready_after_stop", rdy_after, 0);
        chk("full_done", done_cnt, hdr + 1);
        chk("full_nwrites", wa.size(), 5);
        if (wa.size() == 5) begin
            chk("full_last_data", wd[3], 32'hD3);
            chk("full_hdr_addr", wa[4], 23'h500);
            chk("full_hdr_val", wd[4], 4);
        end

        // reset during the header write, then a zero-length capture
        wa.delete(); wd.delete(); lat = 30;
        start(23'h600);
        feed(1, 32'hE0, 20);
        stop_pulse();
        hdr = 0;
        for (int t = 0; t < 200 && hdr == 0; t++) begin
            @(negedge clk); #1;
            if (rec_write && rec_addr == 23'h600) hdr = 1;
        end
        chk("wl_reached", hdr, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("wl_rst_write", rec_write, 0);
        rst = 1'b0;
        hdr = 0;
        foreach (wa[i]) if (wa[i] == 23'h600) hdr++;
        chk("wl_no_header", hdr, 0);
        wa.delete(); wd.delete(); lat = 2;
        start(23'h200);
        stop_pulse();
        wait_done(100);
        chk("zero_nwrites", wa.size(), 1);
        if (wa.size() == 1) begin chk("zero_hdr_addr", wa[0], 23'h200); chk("zero_hdr_val", wd[0], 0); end

        // capacity limit on instance B, no stop
        @(negedge clk); b_select = 23'h700; b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        bacc = 0;
        for (int t = 0; t < 60 && b_done_cnt == 0; t++) begin
            @(negedge clk);
            b_valid = (bacc < 6); b_data = 32'hF0 + bacc; #1;
            if (b_valid && b_ready) bacc++;
        end
        b_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("cap_accepted", bacc, 3);
        chk("cap_done", b_done_cnt, 1);
        chk("cap_nwrites", ba.size(), 4);
        if (ba.size() == 4) begin
            chk("cap_s2_addr", ba[2], 23'h703);
            chk("cap_s2_data", bd[2], 32'hF2);
            chk("cap_hdr_addr", ba[3], 23'h700);
            chk("cap_hdr_val", bd[3], 3);
        end

        chk("hold_stable", stab_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
